pcie_dma_queue_ctrl: RTL and testbench
======================================

PCIE_DMA_QUEUE_CTRL -- requirements
Module: pcie_dma_queue_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, the number of DMA channels (1..8).
REQ-002 SHALL have parameter QDEPTH, default 4, the descriptor FIFO depth per channel (power of 2, at least 2).
REQ-003 SHALL have parameter ADDR_WIDTH, default 64, the source and destination address width.
REQ-004 SHALL have parameter LEN_WIDTH, default 32, the transfer length width in bytes.
REQ-005 SHALL have parameter MSI_BASE, default 32'h0000_0010, the MSI vector for channel 0.
REQ-006 Ports SHALL be as follows; one clock, reset asynchronous active-low:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- desc_valid  in  1  descriptor push strobe
- desc_ready  out  1  target channel FIFO not full
- desc_ch  in  $clog2(NUM_CH)  target channel
- desc_src, desc_dst  in  ADDR_WIDTH  addresses
- desc_len  in  LEN_WIDTH  byte count
- desc_write  in  1  direction
- dma_req_valid  out  1  request to DMA engine
- dma_req_ready  in  1  engine accepts
- dma_src_addr, dma_dst_addr  out  ADDR_WIDTH
- dma_length  out  LEN_WIDTH
- dma_write  out  1
- dma_ch  out  $clog2(NUM_CH)
- dma_done, dma_error  in  1  completion pulses
- msi_vector  out  32
- msi_valid  out  1
- msi_ready  in  1
- ch_level  out  NUM_CH*($clog2(QDEPTH)+1)  FIFO occupancy per channel
- err_count  out  16  saturating error counter
- zero_len_err  out  1  sticky flag

Function
REQ-007 A push SHALL occur on desc_valid && desc_ready; desc_ready SHALL be the combinational not-full of FIFO[desc_ch].
- A push with desc_len==0 SHALL be discarded and SHALL set zero_len_err.
REQ-008 The FSM SHALL have states IDLE, ISSUE and WAIT (plus RETRY when enabled).
REQ-009 IDLE SHALL select the next non-empty channel round-robin, starting after the last served channel.
- It SHALL register that channel's FIFO head onto the dma_* outputs and go to ISSUE.
- dma_req_valid SHALL rise on the cycle after selection.
REQ-010 In ISSUE, dma_req_valid and all dma_* outputs SHALL stay stable until dma_req_ready; then go to WAIT with dma_req_valid deasserted.
REQ-011 Only one request SHALL be outstanding at a time; dma_done and dma_error SHALL be ignored outside WAIT.
REQ-012 On dma_done in WAIT: pop the head, set pend[ch], go to IDLE.
REQ-013 On dma_error in WAIT: pop the head, increment err_count (saturating at 16'hFFFF), set pend[ch], go to IDLE.
- If dma_done and dma_error arrive in the same cycle, error SHALL win.
REQ-014 A push and a pop on the same channel in the same cycle SHALL both take effect and leave the level unchanged; a push to a full channel SHALL be blocked even if that channel pops in the same cycle.
REQ-015 When msi_valid is low and any pend bit is set, the block SHALL present the lowest pending channel: msi_vector = MSI_BASE + ch, msi_valid = 1.
- The MSI SHALL hold until msi_ready, then clear that pend bit.
- A new completion on a channel already pending SHALL coalesce into the existing pend bit.
REQ-016 FIFO and round-robin pointers SHALL wrap modulo QDEPTH and NUM_CH respectively.

Reset
REQ-017 On reset: all FIFOs empty; ch_level = 0; FSM in IDLE; RR pointer at NUM_CH-1; outputs cleared (dma_req_valid = 0, dma_* = 0, msi_valid = 0, msi_vector = 0, pend = 0, err_count = 0, zero_len_err = 0).
REQ-018 Reset asserted mid-transfer SHALL abandon the in-flight request with no MSI; completions arriving after reset release SHALL be ignored.

Configuration
REQ-019 With PCIE_DMA_ERR_RETRY_EN defined, the first dma_error on a descriptor SHALL go to RETRY: increment err_count, no pop, reissue the same request on the next cycle.
- A second error on that descriptor SHALL follow REQ-013.
- Without the macro there SHALL be no RETRY state and no retry.

Structure
REQ-020 Package pcie_dma_pkg SHALL hold the FSM state enum, the descriptor struct (src, dst, len, write) and the MSI_BASE default.
REQ-021 Sub-module pcie_dma_desc_fifo SHALL be a single-channel synchronous FIFO instantiated NUM_CH times.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Push ch0 src=0x1000, dst=0x2000, len=64 -> dma_req_valid 2 cycles later with matching fields, dma_ch=0.
- One descriptor each on ch0..ch3, dma_req_ready and dma_done always 1 -> issue order 0,1,2,3 and MSI vectors 0x10,0x11,0x12,0x13.
- Push 5 descriptors to ch1 with QDEPTH=4 -> fifth blocked with desc_ready=0 and ch_level[1]=4.
- dma_done and dma_error in the same cycle -> err_count=1, vector 0x10 raised once.
- Error with PCIE_DMA_ERR_RETRY_EN defined -> identical request reissued and err_count=1; second error -> pop and err_count=2.
- desc_len=0 -> no push, zero_len_err=1, dma_req_valid stays 0.

Source files
------------

// File: rtl/pcie_dma_pkg.sv
// Shared types for the PCIe DMA queue controller.
// Optional macro PCIE_DMA_ERR_RETRY_EN adds the RETRY state.
package pcie_dma_pkg;

    localparam logic [31:0] MSI_BASE_DEFAULT = 32'h0000_0010;

    // Descriptor storage is sized for the widest supported configuration.
    localparam int DESC_ADDR_W = 64;
    localparam int DESC_LEN_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
`ifdef PCIE_DMA_ERR_RETRY_EN
        , RETRY
`endif
    } dma_state_t;

    typedef struct packed {
        logic [DESC_ADDR_W-1:0] src;
        logic [DESC_ADDR_W-1:0] dst;
        logic [DESC_LEN_W-1:0]  len;
        logic                   write;
    } desc_t;

endpackage

// File: rtl/pcie_dma_desc_fifo.sv
// Single-channel descriptor FIFO; push and pop may coincide, a full FIFO
// refuses pushes regardless of a same-cycle pop.
module pcie_dma_desc_fifo
    import pcie_dma_pkg::*;
#(
    parameter int QDEPTH = 4,
    localparam int PW = $clog2(QDEPTH),
    localparam int LW = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  desc_t         din,
    input  logic          pop,
    output desc_t         head,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    desc_t         mem [QDEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(QDEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally since QDEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      level <= level + LW'(1);
            else if (do_pop && !do_push) level <= level - LW'(1);
        end
    end

endmodule

// File: rtl/pcie_dma_queue_ctrl.sv
// Multi-channel DMA descriptor queue: round-robin issue, one request in flight,
// coalesced per-channel MSI. Define PCIE_DMA_ERR_RETRY_EN for single retry on error.
module pcie_dma_queue_ctrl
    import pcie_dma_pkg::*;
#(
    parameter int          NUM_CH     = 4,
    parameter int          QDEPTH     = 4,
    parameter int          ADDR_WIDTH = 64,
    parameter int          LEN_WIDTH  = 32,
    parameter logic [31:0] MSI_BASE   = MSI_BASE_DEFAULT,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int LW   = $clog2(QDEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   desc_valid,
    output logic                   desc_ready,
    input  logic [CH_W-1:0]        desc_ch,
    input  logic [ADDR_WIDTH-1:0]  desc_src,
    input  logic [ADDR_WIDTH-1:0]  desc_dst,
    input  logic [LEN_WIDTH-1:0]   desc_len,
    input  logic                   desc_write,
    output logic                   dma_req_valid,
    input  logic                   dma_req_ready,
    output logic [ADDR_WIDTH-1:0]  dma_src_addr,
    output logic [ADDR_WIDTH-1:0]  dma_dst_addr,
    output logic [LEN_WIDTH-1:0]   dma_length,
    output logic                   dma_write,
    output logic [CH_W-1:0]        dma_ch,
    input  logic                   dma_done,
    input  logic                   dma_error,
    output logic [31:0]            msi_vector,
    output logic                   msi_valid,
    input  logic                   msi_ready,
    output logic [NUM_CH*LW-1:0]   ch_level,
    output logic [15:0]            err_count,
    output logic                   zero_len_err
);

    dma_state_t                    state, state_d;
    desc_t                         din;
    desc_t                         head [NUM_CH];
    logic [NUM_CH-1:0]             full, empty, push, pop;
    logic [NUM_CH-1:0][LW-1:0]     level;
    logic [CH_W-1:0]               rr;
    logic                          sel_found;
    logic [CH_W-1:0]               sel_ch;
    logic                          push_ok;
    logic                          complete;
    logic                          retry_now;
    logic [NUM_CH-1:0]             pend, pend_set, pend_clr;
    logic [CH_W-1:0]               msi_ch, msi_sel;
    int                            idx;
`ifdef PCIE_DMA_ERR_RETRY_EN
    logic                          retried;
`endif

    assign din = '{src: DESC_ADDR_W'(desc_src), dst: DESC_ADDR_W'(desc_dst),
                   len: DESC_LEN_W'(desc_len), write: desc_write};

    always_comb begin
        desc_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++)
            if (desc_ch == CH_W'(i)) desc_ready = !full[i];
    end

    // Zero-length descriptors are accepted on the handshake but never stored.
    assign push_ok = desc_valid && desc_ready && (desc_len != '0);

`ifdef PCIE_DMA_ERR_RETRY_EN
    assign retry_now = (state == WAIT) && dma_error && !retried;
`else
    assign retry_now = 1'b0;
`endif
    assign complete = (state == WAIT) && (dma_done || dma_error) && !retry_now;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            push[i]     = push_ok && (desc_ch == CH_W'(i));
            pop[i]      = complete && (dma_ch == CH_W'(i));
            pend_set[i] = pop[i];
            pend_clr[i] = msi_valid && msi_ready && (msi_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pcie_dma_desc_fifo #(.QDEPTH(QDEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[g]),
            .din   (din),
            .pop   (pop[g]),
            .head  (head[g]),
            .full  (full[g]),
            .empty (empty[g]),
            .level (level[g])
        );
        assign ch_level[g*LW +: LW] = level[g];
    end

    // Scan starts one past the last served channel.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(rr) + k) % NUM_CH;
            if (!sel_found && !empty[idx]) begin
                sel_found = 1'b1;
                sel_ch    = CH_W'(idx);
            end
        end
    end

    always_comb begin
        msi_sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (pend[i]) msi_sel = CH_W'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:  if (sel_found) state_d = ISSUE;
            ISSUE: if (dma_req_ready) state_d = WAIT;
            WAIT: begin
`ifdef PCIE_DMA_ERR_RETRY_EN
                if (retry_now) state_d = RETRY;
                else
`endif
                if (dma_done || dma_error) state_d = IDLE;
            end
`ifdef PCIE_DMA_ERR_RETRY_EN
            RETRY: state_d = ISSUE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dma_req_valid <= 1'b0;
            dma_src_addr  <= '0;
            dma_dst_addr  <= '0;
            dma_length    <= '0;
            dma_write     <= 1'b0;
            dma_ch        <= '0;
            rr            <= CH_W'(NUM_CH - 1);
            err_count     <= '0;
            zero_len_err  <= 1'b0;
        end else begin
            if (state == IDLE && sel_found) begin
                dma_src_addr  <= head[sel_ch].src[ADDR_WIDTH-1:0];
                dma_dst_addr  <= head[sel_ch].dst[ADDR_WIDTH-1:0];
                dma_length    <= head[sel_ch].len[LEN_WIDTH-1:0];
                dma_write     <= head[sel_ch].write;
                dma_ch        <= sel_ch;
                rr            <= sel_ch;
                dma_req_valid <= 1'b1;
            end
            if (state == ISSUE && dma_req_ready) dma_req_valid <= 1'b0;
`ifdef PCIE_DMA_ERR_RETRY_EN
            if (state == RETRY) dma_req_valid <= 1'b1;
`endif
            if (state == WAIT && dma_error && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
            if (desc_valid && desc_ready && desc_len == '0)
                zero_len_err <= 1'b1;
        end
    end

`ifdef PCIE_DMA_ERR_RETRY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         retried <= 1'b0;
        else if (retry_now) retried <= 1'b1;
        else if (complete)  retried <= 1'b0;
    end
`endif

    // A completion landing as its channel's MSI is acknowledged re-arms the bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend       <= '0;
            msi_valid  <= 1'b0;
            msi_vector <= '0;
            msi_ch     <= '0;
        end else begin
            pend <= (pend & ~pend_clr) | pend_set;
            if (msi_valid) begin
                if (msi_ready) msi_valid <= 1'b0;
            end else if (|pend) begin
                msi_valid  <= 1'b1;
                msi_vector <= MSI_BASE + 32'(msi_sel);
                msi_ch     <= msi_sel;
            end
        end
    end

endmodule

// File: tb/tb_pcie_dma_queue_ctrl.sv
// Directed bench for pcie_dma_queue_ctrl: push table plus hand-written sequences.
module tb_pcie_dma_queue_ctrl;

    localparam int NUM_CH = 4;
    localparam int QDEPTH = 4;
    localparam int LW     = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        desc_valid, desc_ready, desc_write;
    logic [1:0]  desc_ch;
    logic [63:0] desc_src, desc_dst;
    logic [31:0] desc_len;
    logic        dma_req_valid, dma_req_ready, dma_write;
    logic [63:0] dma_src_addr, dma_dst_addr;
    logic [31:0] dma_length;
    logic [1:0]  dma_ch;
    logic        dma_done, dma_error;
    logic [31:0] msi_vector;
    logic        msi_valid, msi_ready;
    logic [NUM_CH*LW-1:0] ch_level;
    logic [15:0] err_count;
    logic        zero_len_err;

    int n_chk = 0;
    int n_fail = 0;

    pcie_dma_queue_ctrl #(.NUM_CH(NUM_CH), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_ch(desc_ch),
        .desc_src(desc_src), .desc_dst(desc_dst), .desc_len(desc_len),
        .desc_write(desc_write),
        .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
        .dma_src_addr(dma_src_addr), .dma_dst_addr(dma_dst_addr),
        .dma_length(dma_length), .dma_write(dma_write), .dma_ch(dma_ch),
        .dma_done(dma_done), .dma_error(dma_error),
        .msi_vector(msi_vector), .msi_valid(msi_valid), .msi_ready(msi_ready),
        .ch_level(ch_level), .err_count(err_count), .zero_len_err(zero_len_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] len;
        logic        exp_ready;
        logic [2:0]  exp_lvl;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] lvl(input int c);
        return 64'(ch_level[c*LW +: LW]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        desc_valid = 0; desc_ch = 0; desc_src = 0; desc_dst = 0; desc_len = 0;
        desc_write = 0; dma_req_ready = 0; dma_done = 0; dma_error = 0; msi_ready = 0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push(input logic [1:0] ch, input logic [63:0] src,
                        input logic [63:0] dst, input logic [31:0] len, input logic wr);
        desc_ch = ch; desc_src = src; desc_dst = dst; desc_len = len; desc_write = wr;
        desc_valid = 1'b1;
        tick();
        desc_valid = 1'b0;
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 20 && !dma_req_valid; i++) tick();
        chk(name, 64'(dma_req_valid), 64'd1);
    endtask

    task automatic issue_and_complete(input logic done, input logic err);
        wait_req("req_valid_wait");
        dma_req_ready = 1'b1;
        tick();
        dma_req_ready = 1'b0;
        dma_done = done; dma_error = err;
        tick();
        dma_done = 1'b0; dma_error = 1'b0;
    endtask

    vec_t vecs[6];
    int   n_iss, n_msi, cnt;
    logic [1:0]  iss[4];
    logic [31:0] msis[4];

    initial begin
        vecs[0] = '{2'd1, 32'd16, 1'b1, 3'd1};
        vecs[1] = '{2'd1, 32'd16, 1'b1, 3'd2};
        vecs[2] = '{2'd1, 32'd16, 1'b1, 3'd3};
        vecs[3] = '{2'd1, 32'd16, 1'b1, 3'd4};
        vecs[4] = '{2'd1, 32'd16, 1'b0, 3'd4};
        vecs[5] = '{2'd2, 32'd8,  1'b1, 3'd1};

        // Reset state and single-descriptor latency
        do_reset();
        chk("rst_req_valid", 64'(dma_req_valid), 0);
        chk("rst_msi_valid", 64'(msi_valid), 0);
        chk("rst_msi_vector", 64'(msi_vector), 0);
        chk("rst_err_count", 64'(err_count), 0);
        chk("rst_zero_len", 64'(zero_len_err), 0);
        chk("rst_ch_level", 64'(ch_level), 0);
        chk("rst_src", dma_src_addr, 0);
        chk("rst_desc_ready", 64'(desc_ready), 1);

        push(2'd0, 64'h1000, 64'h2000, 32'd64, 1'b1);
        chk("lat_level0", lvl(0), 1);
        chk("lat_valid_early", 64'(dma_req_valid), 0);
        tick();
        chk("lat_valid", 64'(dma_req_valid), 1);
        chk("lat_src", dma_src_addr, 64'h1000);
        chk("lat_dst", dma_dst_addr, 64'h2000);
        chk("lat_len", 64'(dma_length), 64);
        chk("lat_write", 64'(dma_write), 1);
        chk("lat_ch", 64'(dma_ch), 0);
        tick();
        chk("issue_hold_valid", 64'(dma_req_valid), 1);
        chk("issue_hold_src", dma_src_addr, 64'h1000);
        dma_req_ready = 1'b1;
        tick();
        dma_req_ready = 1'b0;
        chk("wait_valid_low", 64'(dma_req_valid), 0);
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        chk("done_level0", lvl(0), 0);
        tick();
        chk("msi_raise", 64'(msi_valid), 1);
        chk("msi_vec0", 64'(msi_vector), 64'h10);
        tick();
        chk("msi_hold", 64'(msi_valid), 1);
        msi_ready = 1'b1;
        tick();
        msi_ready = 1'b0;
        chk("msi_clear", 64'(msi_valid), 0);

        // Round-robin issue order and MSI order across four channels
        do_reset();
        for (int c = 0; c < 4; c++)
            push(2'(c), 64'h100 * (c + 1), 64'h8000 + 64'(c), 32'd16, 1'b0);
        dma_req_ready = 1'b1; dma_done = 1'b1; msi_ready = 1'b1;
        n_iss = 0; n_msi = 0;
        for (int t = 0; t < 40; t++) begin
            if (dma_req_valid) begin
                if (n_iss < 4) iss[n_iss] = dma_ch;
                n_iss++;
            end
            if (msi_valid) begin
                if (n_msi < 4) msis[n_msi] = msi_vector;
                n_msi++;
            end
            tick();
        end
        dma_req_ready = 1'b0; dma_done = 1'b0; msi_ready = 1'b0;
        chk("rr_issue_count", 64'(n_iss), 4);
        chk("rr_msi_count", 64'(n_msi), 4);
        for (int i = 0; i < 4 && i < n_iss; i++) chk("rr_issue_order", 64'(iss[i]), 64'(i));
        for (int i = 0; i < 4 && i < n_msi; i++) chk("rr_msi_vector", 64'(msi_vecs_ok(msis[i])), 64'(32'h10 + i));

        // Full FIFO blocks the fifth push (table-driven)
        do_reset();
        foreach (vecs[i]) begin
            desc_ch = vecs[i].ch; desc_len = vecs[i].len;
            desc_src = 64'h4000 + 64'(i); desc_dst = 64'h5000; desc_write = 1'b0;
            desc_valid = 1'b1;
            #1;
            chk("tbl_desc_ready", 64'(desc_ready), 64'(vecs[i].exp_ready));
            tick();
            desc_valid = 1'b0;
            chk("tbl_level", lvl(int'(vecs[i].ch)), 64'(vecs[i].exp_lvl));
        end

        // Simultaneous done and error: error wins, single MSI
        do_reset();
        push(2'd0, 64'h3000, 64'h3100, 32'd4, 1'b0);
        issue_and_complete(1'b1, 1'b1);
`ifdef PCIE_DMA_ERR_RETRY_EN
        chk("both_retry_err", 64'(err_count), 1);
        issue_and_complete(1'b1, 1'b1);
        chk("both_err_count", 64'(err_count), 2);
`else
        chk("both_err_count", 64'(err_count), 1);
`endif
        chk("both_level0", lvl(0), 0);
        msi_ready = 1'b1; cnt = 0;
        for (int t = 0; t < 10; t++) begin
            if (msi_valid) begin
                cnt++;
                chk("both_msi_vector", 64'(msi_vector), 64'h10);
            end
            tick();
        end
        msi_ready = 1'b0;
        chk("both_msi_count", 64'(cnt), 1);

        // Error handling on ch2 (retry when enabled)
        do_reset();
        push(2'd2, 64'hA000, 64'hB000, 32'd128, 1'b1);
        issue_and_complete(1'b0, 1'b1);
        chk("err1_count", 64'(err_count), 1);
`ifdef PCIE_DMA_ERR_RETRY_EN
        chk("retry_level2", lvl(2), 1);
        chk("retry_no_msi", 64'(msi_valid), 0);
        wait_req("retry_reissue");
        chk("retry_src", dma_src_addr, 64'hA000);
        chk("retry_dst", dma_dst_addr, 64'hB000);
        chk("retry_len", 64'(dma_length), 128);
        chk("retry_ch", 64'(dma_ch), 2);
        issue_and_complete(1'b0, 1'b1);
        chk("err2_count", 64'(err_count), 2);
        chk("err2_level2", lvl(2), 0);
`else
        chk("err_level2", lvl(2), 0);
        tick();
        chk("err_msi_valid", 64'(msi_valid), 1);
        chk("err_msi_vector", 64'(msi_vector), 64'h12);
`endif

        // Zero-length descriptor is dropped and flagged
        do_reset();
        push(2'd0, 64'h7000, 64'h7100, 32'd0, 1'b0);
        chk("zlen_flag", 64'(zero_len_err), 1);
        chk("zlen_level0", lvl(0), 0);
        cnt = 0;
        for (int t = 0; t < 6; t++) begin
            if (dma_req_valid) cnt++;
            tick();
        end
        chk("zlen_no_req", 64'(cnt), 0);
        chk("zlen_sticky", 64'(zero_len_err), 1);

        // Reset mid-transfer abandons the request; later completions are ignored
        do_reset();
        push(2'd3, 64'h9000, 64'h9100, 32'd32, 1'b0);
        wait_req("midrst_req");
        dma_req_ready = 1'b1;
        tick();
        dma_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(dma_req_valid), 0);
        chk("midrst_level", 64'(ch_level), 0);
        tick();
        rst_n = 1'b1;
        dma_done = 1'b1; dma_error = 1'b1; cnt = 0;
        for (int t = 0; t < 6; t++) begin
            if (msi_valid || dma_req_valid) cnt++;
            tick();
        end
        dma_done = 1'b0; dma_error = 1'b0;
        chk("midrst_quiet", 64'(cnt), 0);
        chk("midrst_err", 64'(err_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    function automatic logic [31:0] msi_vecs_ok(input logic [31:0] v);
        return v;
    endfunction

endmodule
